// File: rtl/mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_if
// Brief    : Bus bundle between the IF/MEM pipeline stages, the shared RAM
//            and the memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  // Instruction-fetch side
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  // Load/store side
  logic                  d_rd_req;
  logic                  d_wr_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  // RAM side
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  // Hazard unit
  logic                  stop;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_rd_req, d_wr_req, d_addr, d_wdata, ram_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, stop
  );

  // Pipeline/RAM view
  modport master (
    output if_req, if_addr, d_rd_req, d_wr_req, d_addr, d_wdata, ram_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, stop
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port unified RAM between instruction fetch and
//            load/store. Round-robin arbitration, MEM_LAT-cycle accesses,
//            one idle cycle between accesses, pipeline freeze via stop.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic      clk,
  input  logic      rst,
  mem_port_if.slave bus
);

  localparam int c_cnt_w = $clog2(MEM_LAT) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_LAT - 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_d_acc = 2'd1;
  localparam logic [1:0] c_i_acc = 2'd2;

  logic [1:0]            r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_last_grant;   // 0 = fetch served last, 1 = data
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [DATA_WIDTH-1:0] r_wdata_q;
  logic                  r_we_q;

  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_d_active;
  logic w_i_active;
  logic w_last;
  logic w_if_ack;
  logic w_d_ack;

  // Arbitration: on a tie the side that was not served last wins
  assign w_dreq    = bus.d_rd_req | bus.d_wr_req;
  assign w_grant_d = w_dreq & (~bus.if_req | ~r_last_grant);
  assign w_grant_i = bus.if_req & ~w_grant_d;

  // Activity decode is gated by reset so every output is 0 while rst=0
  assign w_d_active = rst & (r_state == c_d_acc);
  assign w_i_active = rst & (r_state == c_i_acc);
  assign w_last     = (r_cnt == c_cnt_last);
  assign w_if_ack   = w_i_active & w_last;
  assign w_d_ack    = w_d_active & w_last;

  // Access sequencer: sample requests only in IDLE, always return to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= c_idle;
      r_cnt        <= '0;
      r_last_grant <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
      r_we_q       <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant_d) begin
            r_state      <= c_d_acc;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_addr_q     <= bus.d_addr;
            r_wdata_q    <= bus.d_wdata;
            r_we_q       <= bus.d_wr_req;   // both requests high -> store
          end else if (w_grant_i) begin
            r_state      <= c_i_acc;
            r_cnt        <= '0;
            r_last_grant <= 1'b0;
            r_addr_q     <= bus.if_addr;
            r_wdata_q    <= '0;
            r_we_q       <= 1'b0;
          end
        end
        c_d_acc, c_i_acc: begin
          if (w_last) begin
            r_state <= c_idle;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // RAM drive is held constant for the whole access
  assign bus.ram_en    = w_d_active | w_i_active;
  assign bus.ram_we    = w_d_active & r_we_q;
  assign bus.ram_addr  = bus.ram_en ? r_addr_q  : '0;
  assign bus.ram_wdata = bus.ram_en ? r_wdata_q : '0;

  // Completion strobes and read data, zero outside the final access cycle
  assign bus.if_ack   = w_if_ack;
  assign bus.d_ack    = w_d_ack;
  assign bus.if_rdata = w_if_ack ? bus.ram_rdata : '0;
  assign bus.d_rdata  = (w_d_ack & ~r_we_q) ? bus.ram_rdata : '0;

  // Freeze the pipeline while any request is outstanding; release on ack
  assign bus.stop = rst & ((bus.if_req & ~w_if_ack) | (w_dreq & ~w_d_ack));

endmodule
`default_nettype wire
